// File: rtl/alu8_pg_stage.sv
// Two-stage 8-bit add/subtract front end for the external carry-lookahead unit.
// Define ALU8_CARRY_CHAIN_EN to keep a carry flag register so ADC/SBB chain across bytes.
module alu8_pg_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic [1:0] in_op,
    output logic [7:0] G,
    output logic [7:0] P,
    output logic       C0,
    input  logic [8:1] C,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sum,
    output logic       out_cf,
    output logic       out_zf,
    output logic       out_nf,
    output logic       out_of
);

    logic       s1_v;
    logic       s2_v;
    logic [7:0] s1_a;
    logic [7:0] s1_b;
    logic [1:0] s1_op;
    logic       accept;
    logic       move;
    logic [7:0] b_eff;
    logic [7:0] sum;
    logic       c0_sel;
`ifdef ALU8_CARRY_CHAIN_EN
    logic       cf_q;
`endif

    assign in_ready  = !s1_v | !s2_v | out_ready;
    assign accept    = in_valid & in_ready;
    assign move      = s1_v & (!s2_v | out_ready);
    assign out_valid = s2_v;

    // Subtraction is a + ~b + 1; the borrow sense is carried as NOT borrow.
    assign b_eff = s1_op[1] ? ~s1_b : s1_b;

    always_comb begin
        c0_sel = 1'b0;
        case (s1_op)
            2'b00:   c0_sel = 1'b0;
            2'b10:   c0_sel = 1'b1;
`ifdef ALU8_CARRY_CHAIN_EN
            default: c0_sel = cf_q;
`else
            2'b01:   c0_sel = 1'b0;
            default: c0_sel = 1'b1;
`endif
        endcase
    end

    assign G   = s1_v ? (s1_a & b_eff) : '0;
    assign P   = s1_v ? (s1_a ^ b_eff) : '0;
    assign C0  = s1_v & c0_sel;
    assign sum = P ^ {C[7:1], C0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v  <= 1'b0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_op <= '0;
        end else if (accept) begin
            s1_v  <= 1'b1;
            s1_a  <= in_a;
            s1_b  <= in_b;
            s1_op <= in_op;
        end else if (move) begin
            s1_v  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v    <= 1'b0;
            out_sum <= '0;
            out_cf  <= 1'b0;
            out_zf  <= 1'b0;
            out_nf  <= 1'b0;
            out_of  <= 1'b0;
        end else if (move) begin
            s2_v    <= 1'b1;
            out_sum <= sum;
            out_cf  <= C[8];
            out_zf  <= (sum == '0);
            out_nf  <= sum[7];
            out_of  <= C[8] ^ C[7];
        end else if (out_ready) begin
            s2_v    <= 1'b0;
        end
    end

`ifdef ALU8_CARRY_CHAIN_EN
    // Tracks the newest op entering s2 so an ADC/SBB in s1 sees its predecessor's carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cf_q <= 1'b0;
        end else if (move) begin
            cf_q <= C[8];
        end
    end
`endif

endmodule

// File: tb/tb_alu8_pg_stage.sv
// Directed bench for alu8_pg_stage with a bit-serial lookahead model closing the carry loop.
module tb_alu8_pg_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [1:0] in_op;
    logic [7:0] G;
    logic [7:0] P;
    logic       C0;
    logic [8:1] C;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_cf;
    logic       out_zf;
    logic       out_nf;
    logic       out_of;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] p;
        logic       c0;
        logic [7:0] sum;
        logic [3:0] flags; // {cf, zf, nf, of}
    } vec_t;

    vec_t vecs [7];

    alu8_pg_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .G         (G),
        .P         (P),
        .C0        (C0),
        .C         (C),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cf    (out_cf),
        .out_zf    (out_zf),
        .out_nf    (out_nf),
        .out_of    (out_of)
    );

    always #5 clk = ~clk;

    // Lookahead unit stand-in: ripple C[i+1] = G[i] | P[i] & C[i].
    always_comb begin
        logic cc;
        C  = '0;
        cc = C0;
        for (int i = 0; i < 8; i++) begin
            cc     = G[i] | (P[i] & cc);
            C[i+1] = cc;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] flags();
        return {out_cf, out_zf, out_nf, out_of};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bp_a [4];
        logic [7:0] bp_b [4];
        logic [7:0] bp_s [4];
        int k;
        int r;
        logic exp_c0;
        logic [7:0] exp_adc;

        //           op     a      b      G      P      C0    sum    cf zf nf of
        vecs[0] = '{2'b00, 8'h7F, 8'h01, 8'h01, 8'h7E, 1'b0, 8'h80, 4'b0011};
        vecs[1] = '{2'b10, 8'h05, 8'h05, 8'h00, 8'hFF, 1'b1, 8'h00, 4'b1100};
        vecs[2] = '{2'b10, 8'h03, 8'h05, 8'h02, 8'hF9, 1'b1, 8'hFE, 4'b0010};
        vecs[3] = '{2'b00, 8'h80, 8'h80, 8'h80, 8'h00, 1'b0, 8'h00, 4'b1101};
        vecs[4] = '{2'b10, 8'h80, 8'h01, 8'h80, 8'h7E, 1'b1, 8'h7F, 4'b1001};
        vecs[5] = '{2'b00, 8'h3C, 8'hC3, 8'h00, 8'hFF, 1'b0, 8'hFF, 4'b0010};
        vecs[6] = '{2'b00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'hFE, 4'b1010};

        bp_a = '{8'h01, 8'h11, 8'h7F, 8'hAA};
        bp_b = '{8'h01, 8'h21, 8'h7F, 8'h55};
        bp_s = '{8'h02, 8'h32, 8'hFE, 8'hFF};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
        step(); step();
        chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
        chk("rst_out_sum", out_sum, 8'h00);
        chk("rst_flags", {4'b0, flags()}, 8'h00);
        chk("rst_G", G, 8'h00);
        chk("rst_P", P, 8'h00);
        chk("rst_C0", {7'b0, C0}, 8'h00);
        chk("rst_in_ready", {7'b0, in_ready}, 8'h01);
        rst = 1'b0;

        // Single requests: G/P/C0 in cycle N+1, result after edge N+1.
        for (int v = 0; v < 7; v++) begin
            in_valid = 1'b1; in_a = vecs[v].a; in_b = vecs[v].b; in_op = vecs[v].op;
            #1;
            chk($sformatf("v%0d_in_ready", v), {7'b0, in_ready}, 8'h01);
            step();
            in_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_G", v), G, vecs[v].g);
            chk($sformatf("v%0d_P", v), P, vecs[v].p);
            chk($sformatf("v%0d_C0", v), {7'b0, C0}, {7'b0, vecs[v].c0});
            chk($sformatf("v%0d_early_valid", v), {7'b0, out_valid}, 8'h00);
            step();
            chk($sformatf("v%0d_out_valid", v), {7'b0, out_valid}, 8'h01);
            chk($sformatf("v%0d_sum", v), out_sum, vecs[v].sum);
            chk($sformatf("v%0d_flags", v), {4'b0, flags()}, {4'b0, vecs[v].flags});
        end

        // Carry chain: ADD FF+01, ADC 00+00, ADC 00+00 back to back.
`ifdef ALU8_CARRY_CHAIN_EN
        exp_c0 = 1'b1; exp_adc = 8'h01;
`else
        exp_c0 = 1'b0; exp_adc = 8'h00;
`endif
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h01; in_op = 2'b00;
        step();
        in_a = 8'h00; in_b = 8'h00; in_op = 2'b01;
        #1;
        chk("cc_add_C0", {7'b0, C0}, 8'h00);
        step();
        #1;
        chk("cc_add_sum", out_sum, 8'h00);
        chk("cc_add_cf", {7'b0, out_cf}, 8'h01);
        chk("cc_adc1_C0", {7'b0, C0}, {7'b0, exp_c0});
        step();
        in_valid = 1'b0;
        #1;
        chk("cc_adc1_sum", out_sum, exp_adc);
        chk("cc_adc1_cf", {7'b0, out_cf}, 8'h00);
        step();
        chk("cc_adc2_sum", out_sum, 8'h00);
        chk("cc_adc2_valid", {7'b0, out_valid}, 8'h01);
        step();

        // Backpressure: 3 cycles of out_ready low while 4 ADDs are offered.
        out_ready = 1'b0; k = 0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            in_valid = 1'b1; in_a = bp_a[k]; in_b = bp_b[k]; in_op = 2'b00;
            #1;
            if (in_ready) k++;
            step();
            if (cyc == 0) begin
                chk("bp_c0_valid", {7'b0, out_valid}, 8'h00);
            end else begin
                chk($sformatf("bp_c%0d_valid", cyc), {7'b0, out_valid}, 8'h01);
                chk($sformatf("bp_c%0d_sum_held", cyc), out_sum, bp_s[0]);
                chk($sformatf("bp_c%0d_G_held", cyc), G, 8'h01);
                chk($sformatf("bp_c%0d_P_held", cyc), P, 8'h30);
            end
        end
        chk("bp_accepted", k[7:0], 8'd2);
        chk("bp_in_ready_low", {7'b0, in_ready}, 8'h00);
        out_ready = 1'b1; r = 0;
        for (int t = 0; t < 20 && r < 4; t++) begin
            if (k < 4) begin
                in_valid = 1'b1; in_a = bp_a[k]; in_b = bp_b[k];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                chk($sformatf("bp_result%0d", r), out_sum, bp_s[r]);
                r++;
            end
            if (in_valid && in_ready) k++;
            step();
        end
        chk("bp_result_count", r[7:0], 8'd4);
        in_valid = 1'b0;
        step();

        // Reset with s1 and s2 both full and cf_q set by the first op.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h01; in_op = 2'b00;
        step();
        in_a = 8'h01; in_b = 8'h02;
        step();
        in_valid = 1'b0;
        chk("mr_pre_valid", {7'b0, out_valid}, 8'h01);
        rst = 1'b1;
        #1;
        chk("mr_out_valid", {7'b0, out_valid}, 8'h00);
        chk("mr_G", G, 8'h00);
        chk("mr_P", P, 8'h00);
        chk("mr_C0", {7'b0, C0}, 8'h00);
        chk("mr_in_ready", {7'b0, in_ready}, 8'h01);
        chk("mr_out_sum", out_sum, 8'h00);
        step();
        rst = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'h10; in_b = 8'h20; in_op = 2'b01;
        step();
        in_valid = 1'b0;
        #1;
        chk("mr_adc_C0", {7'b0, C0}, 8'h00);
        chk("mr_adc_P", P, 8'h30);
        step();
        chk("mr_adc_valid", {7'b0, out_valid}, 8'h01);
        chk("mr_adc_sum", out_sum, 8'h30);
        step();

        // Idle: nothing offered, nothing produced.
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("idle%0d_G", i), G, 8'h00);
            chk($sformatf("idle%0d_P", i), P, 8'h00);
            chk($sformatf("idle%0d_C0", i), {7'b0, C0}, 8'h00);
            chk($sformatf("idle%0d_valid", i), {7'b0, out_valid}, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
